// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   MEM/WB pipeline register and writeback unit of the pipelined RV32I core.
//   It captures the memory-stage slot, extracts and extends load data, picks
//   the writeback value, and drives the register file write port. It also
//   flags illegal or misaligned loads and counts retired instructions.
//
// Ports
//   clk            core clock, rising edge
//   rst            asynchronous active-low reset
//   in_valid       MEM slot holds a real instruction
//   stall          hold contents, block commit
//   flush          turn the incoming slot into a bubble (wins over stall)
//   in_alu_result  ALU result
//   in_mem_rdata   raw aligned word from data memory
//   in_pc_plus4    return address for JAL/JALR
//   in_imm         LUI immediate
//   in_wb_sel      00 ALU, 01 MEM, 10 PC+4, 11 IMM
//   in_funct3      load type
//   in_addr_lo     byte offset of the load address
//   in_rd          destination register
//   in_reg_write   instruction writes rd
//   write_reg      register file write index
//   write_data     register file write data / forwarding value
//   RegWrite       register file write enable
//   wb_valid       stage holds a valid instruction
//   load_err       committing load is misaligned or illegal
//   instret        committed instruction count (wraps)
//
// Flow control: a slot is accepted on every edge where flush=0 and stall=0
// (valid_q follows in_valid). stall=1 holds the slot and suppresses commit;
// flush=1 empties the slot regardless of stall. The held slot commits in the
// first cycle where valid_q=1 and stall=0.
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         stall,
  input  logic         flush,
  input  logic [N-1:0] in_alu_result,
  input  logic [N-1:0] in_mem_rdata,
  input  logic [N-1:0] in_pc_plus4,
  input  logic [N-1:0] in_imm,
  input  logic [1:0]   in_wb_sel,
  input  logic [2:0]   in_funct3,
  input  logic [1:0]   in_addr_lo,
  input  logic [4:0]   in_rd,
  input  logic         in_reg_write,
  output logic [4:0]   write_reg,
  output logic [N-1:0] write_data,
  output logic         RegWrite,
  output logic         wb_valid,
  output logic         load_err,
  output logic [N-1:0] instret
);

  logic         valid_q, valid_d;
  logic [N-1:0] alu_q, alu_d;
  logic [N-1:0] rdata_q, rdata_d;
  logic [N-1:0] pc4_q, pc4_d;
  logic [N-1:0] imm_q, imm_d;
  logic [1:0]   sel_q, sel_d;
  logic [2:0]   f3_q, f3_d;
  logic [1:0]   lo_q, lo_d;
  logic [4:0]   rd_q, rd_d;
  logic         rw_q, rw_d;
  logic [N-1:0] instret_q, instret_d;

  logic [7:0]   byte_sel;
  logic [15:0]  half_sel;
  logic [N-1:0] load_data;
  logic         err;
  logic         commit;

  // Capture priority: flush, then stall (hold), then load.
  always_comb begin
    valid_d = valid_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    pc4_d   = pc4_q;
    imm_d   = imm_q;
    sel_d   = sel_q;
    f3_d    = f3_q;
    lo_d    = lo_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d = in_valid;
      alu_d   = in_alu_result;
      rdata_d = in_mem_rdata;
      pc4_d   = in_pc_plus4;
      imm_d   = in_imm;
      sel_d   = in_wb_sel;
      f3_d    = in_funct3;
      lo_d    = in_addr_lo;
      rd_d    = in_rd;
      rw_d    = in_reg_write;
    end
  end

  // Little-endian lane selection; halfword lane is chosen by lo_q[1] only.
  always_comb begin
    byte_sel = rdata_q[7:0];
    case (lo_q)
      2'd0: byte_sel = rdata_q[7:0];
      2'd1: byte_sel = rdata_q[15:8];
      2'd2: byte_sel = rdata_q[23:16];
      2'd3: byte_sel = rdata_q[31:24];
      default: byte_sel = rdata_q[7:0];
    endcase
    half_sel = lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
  end

  always_comb begin
    load_data = rdata_q;
    case (f3_q)
      3'b000:  load_data = {{(N-8){byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {{(N-8){1'b0}}, byte_sel};
      3'b001:  load_data = {{(N-16){half_sel[15]}}, half_sel};
      3'b101:  load_data = {{(N-16){1'b0}}, half_sel};
      default: load_data = rdata_q;
    endcase
  end

  always_comb begin
    err = 1'b0;
    if (sel_q == 2'b01) begin
      case (f3_q)
        3'b011, 3'b110, 3'b111: err = 1'b1;
        3'b001, 3'b101:         err = lo_q[0];
        3'b010:                 err = (lo_q != 2'b00);
        default:                err = 1'b0;
      endcase
    end
  end

  // Writeback mux is driven regardless of validity for the forwarding path.
  always_comb begin
    write_data = alu_q;
    case (sel_q)
      2'b00:   write_data = alu_q;
      2'b01:   write_data = load_data;
      2'b10:   write_data = pc4_q;
      2'b11:   write_data = imm_q;
      default: write_data = alu_q;
    endcase
  end

  assign commit    = valid_q & ~stall;
  assign RegWrite  = commit & rw_q & (rd_q != 5'd0) & ~err;
  assign load_err  = commit & err;
  assign write_reg = rd_q;
  assign wb_valid  = valid_q;
  assign instret   = instret_q;

  assign instret_d = (commit && !err) ? instret_q + 1'b1 : instret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      alu_q     <= '0;
      rdata_q   <= '0;
      pc4_q     <= '0;
      imm_q     <= '0;
      sel_q     <= 2'b00;
      f3_q      <= 3'b000;
      lo_q      <= 2'b00;
      rd_q      <= 5'd0;
      rw_q      <= 1'b0;
      instret_q <= '0;
    end else begin
      valid_q   <= valid_d;
      alu_q     <= alu_d;
      rdata_q   <= rdata_d;
      pc4_q     <= pc4_d;
      imm_q     <= imm_d;
      sel_q     <= sel_d;
      f3_q      <= f3_d;
      lo_q      <= lo_d;
      rd_q      <= rd_d;
      rw_q      <= rw_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and writeback unit of the pipelined RV32I core. Captures the memory-stage result each cycle, aligns and sign/zero-extends load data, and selects the writeback value. Drives the register file write port (`write_reg`, `write_data`, `RegWrite`) and the forwarding path. Also flags misaligned or illegal loads and maintains a retired-instruction counter.

## Interface
- `N`, 32, datapath width.
- `clk` input 1, core clock; all state updates on its rising edge.
- `rst` input 1, asynchronous, active-low reset.
- `in_valid` input 1, the MEM-stage slot holds a real instruction.
- `stall` input 1, hold this stage's contents and block commit.
- `flush` input 1, discard the incoming MEM-stage slot (bubble inserted).
- `in_alu_result` input N, ALU result.
- `in_mem_rdata` input N, raw aligned word from data memory.
- `in_pc_plus4` input N, return address for JAL/JALR.
- `in_imm` input N, immediate for LUI.
- `in_wb_sel` input 2, writeback source: 00 ALU, 01 MEM, 10 PC+4, 11 IMM.
- `in_funct3` input 3, load type.
- `in_addr_lo` input 2, byte offset of the load address.
- `in_rd` input 5, destination register.
- `in_reg_write` input 1, instruction writes `rd`.
- `write_reg` output 5, register file write index.
- `write_data` output N, register file write data; also the forwarding value.
- `RegWrite` output 1, register file write enable.
- `wb_valid` output 1, this stage holds a valid instruction.
- `load_err` output 1, the committing load is misaligned or illegal.
- `instret` output N, count of committed instructions.

## Operation
- Pipeline register fields: `valid_q`, `alu_q`, `rdata_q`, `pc4_q`, `imm_q`, `sel_q`, `f3_q`, `lo_q`, `rd_q`, `rw_q`.
- Capture priority at each edge:
  - `flush` = 1: `valid_q` <= 0; other fields are don't-care.
  - Otherwise, `stall` = 1: hold all fields.
  - Otherwise: load all fields from the inputs; `valid_q` <= `in_valid`.
- Load extraction (used only when `sel_q` = 01; little-endian):
  - 000 LB: byte `lo_q`, sign-extended.
  - 100 LBU: byte `lo_q`, zero-extended.
  - 001 LH: halfword `lo_q[1]`, sign-extended.
  - 101 LHU: halfword `lo_q[1]`, zero-extended.
  - 010 LW: full word.
- Load error condition: `sel_q` = 01 AND one of:
  - `f3_q` ∈ {011, 110, 111} (illegal).
  - LH/LHU with `lo_q[0]` = 1 (misaligned).
  - LW with `lo_q` ≠ 00 (misaligned).
- `write_data` is the combinational mux of the registered fields per `sel_q`. It is driven regardless of validity, so forwarding sees a stable value.
- `write_reg` = `rd_q`; `wb_valid` = `valid_q`.
- Commit cycle: `valid_q` = 1 AND `stall` = 0.
- `RegWrite` = commit AND `rw_q` AND `rd_q` ≠ 0 AND NOT err.
- `load_err` = commit AND err. RegWrite is suppressed on error.
- `instret` increments by 1 on each edge ending a commit cycle without err. It wraps from 2^N−1 to 0.

## Timing
- Latency is 1 cycle: inputs captured at edge k appear on the outputs after edge k, and write the register file at edge k+1 (if not stalled).
- During stall the contents are held and RegWrite/load_err are 0. The instruction commits exactly once, in the first cycle after stall deasserts.
- `flush` together with `stall` gives flush priority: the slot becomes a bubble.
- Reset (`rst` = 0, any time, including mid-stall) clears all fields and `instret` immediately:
  - `valid_q` = 0, `write_reg` = 0, `write_data` = 0.
  - `RegWrite` = 0, `wb_valid` = 0, `load_err` = 0, `instret` = 0.
- Release of `rst` is synchronous to `clk`; the first capture happens on the first edge with `rst` = 1.
- `rd` = 0 with `in_reg_write` = 1: the instruction commits and counts in `instret`, but RegWrite stays 0.

## Test plan
- ALU op: rd=5, sel=00, alu=0x1234 → next cycle RegWrite=1, write_reg=5, write_data=0x1234, instret 0→1.
- Loads with rdata=0x80FF7F01:
  - LB lo=3 → 0xFFFFFF80.
  - LBU lo=1 → 0x0000007F.
  - LH lo=2 → 0xFFFF80FF.
  - LHU lo=0 → 0x00007F01.
  - LW → 0x80FF7F01.
- LW with lo=2, and funct3=011: load_err=1 for one cycle, RegWrite=0, instret unchanged.
- Stall: capture JAL (sel=10, pc4=0x104, rd=1), hold stall 3 cycles → RegWrite=0 throughout; releases with exactly one write of 0x104; instret +1.
- Flush together with stall on a valid input → wb_valid=0 and no write. Also: rd=0 write → RegWrite=0 while instret still increments.
- Reset mid-stream: assert rst=0 asynchronously between edges → all outputs go to 0 immediately, instret=0; normal capture resumes after release.
